// File: rtl/float_conv_if.sv
// Request/result bus of float_conv_arbiter: two requesters, one normalized-result consumer.
interface float_conv_if;
  logic       req0;
  logic [7:0] U0;
  logic       ack0;
  logic       req1;
  logic [7:0] U1;
  logic       ack1;
  logic [7:0] F;
  logic [2:0] P;
  logic       id;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  // Environment side: requesters plus result consumer
  modport master (
    output req0, U0, req1, U1, out_ready,
    input  ack0, ack1, F, P, id, out_valid, busy
  );

  // Converter side
  modport slave (
    input  req0, U0, req1, U1, out_ready,
    output ack0, ack1, F, P, id, out_valid, busy
  );
endinterface

// File: rtl/float_conv_arbiter.sv
// Two-requester arbiter feeding an 8-bit unsigned -> (mantissa, exponent) normalizer.
// Define FLOAT_ARB_RR_EN for round-robin tie breaking; default is fixed priority to requester 0.
module float_conv_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  float_conv_if.slave bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned EW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   s_q, s_d;
  logic [DW-1:0]   f_q, f_d;
  logic [EW-1:0]   p_q, p_d;
  logic            id_q, id_d;
  logic            out_valid_q;
  logic            busy_q;
  logic            ack0_c, ack1_c;
  logic            gnt_any_c;
  logic            gnt_id_c;

  assign gnt_any_c = bus.req0 | bus.req1;

`ifdef FLOAT_ARB_RR_EN
  // last_q holds the most recently served requester; a tie goes to the other one
  logic last_q, last_d;
  assign gnt_id_c = (bus.req0 && bus.req1) ? ~last_q : ~bus.req0;
`else
  assign gnt_id_c = ~bus.req0;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    f_d     = f_q;
    p_d     = p_q;
    id_d    = id_q;
    ack0_c  = 1'b0;
    ack1_c  = 1'b0;
`ifdef FLOAT_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any_c) begin
          ack0_c  = ~gnt_id_c;
          ack1_c  = gnt_id_c;
          s_d     = gnt_id_c ? bus.U1 : bus.U0;
          p_d     = EW'(7);
          id_d    = gnt_id_c;
          state_d = NORM;
`ifdef FLOAT_ARB_RR_EN
          last_d  = gnt_id_c;
`endif
        end
      end
      NORM: begin
        if (s_q == DW'(0)) begin
          f_d     = DW'(0);
          p_d     = EW'(0);
          state_d = DONE;
        end else if (s_q[DW-1]) begin
          f_d     = s_q;
          state_d = DONE;
        end else begin
          s_d = {s_q[DW-2:0], 1'b0};
          p_d = p_q - EW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; out_valid/busy are registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= DW'(0);
      f_q         <= DW'(0);
      p_q         <= EW'(0);
      id_q        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      f_q         <= f_d;
      p_q         <= p_d;
      id_q        <= id_d;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

`ifdef FLOAT_ARB_RR_EN
  // Reset value 1 makes requester 0 win the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  assign bus.ack0      = ack0_c;
  assign bus.ack1      = ack1_c;
  assign bus.F         = f_q;
  assign bus.P         = p_q;
  assign bus.id        = id_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  // A shift is only taken while the exponent still has room
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == NORM && s_q != DW'(0) && !s_q[DW-1]) |-> (p_q != EW'(0)));

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(ack0_c && ack1_c));

  a_done_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DONE && !bus.out_ready) |=> (state_q == DONE && $stable(f_q) && $stable(p_q) && $stable(id_q)));

endmodule

// File: tb/tb_float_conv_arbiter.sv
// Directed self-checking bench for float_conv_arbiter: vector table plus hold, tie and reset sequences.
module tb_float_conv_arbiter;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  float_conv_if bus();

  float_conv_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, ended=0 required=1");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         r;
    logic [7:0] u;
    int         lat;
    logic [7:0] f;
    logic [2:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One request, wait for its result, optionally stall the consumer, then complete the handshake
  task automatic do_conv(input bit r, input logic [7:0] u, input int lat,
                         input logic [7:0] f, input logic [2:0] p, input int hold,
                         input string name);
    int n;
    int t_ack;
    logic [7:0] f_s;
    logic [2:0] p_s;
    logic       id_s;
    bus.out_ready = (hold == 0);
    if (r) begin bus.req1 = 1'b1; bus.U1 = u; end
    else   begin bus.req0 = 1'b1; bus.U0 = u; end
    #1;
    n = 0;
    while (!(r ? bus.ack1 : bus.ack0) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk({name, " ack"}, 32'(n < 50), 32'd1);
    t_ack = cyc;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk); n++;
    end
    chk({name, " latency"}, 32'(cyc - t_ack), 32'(lat));
    chk({name, " F"}, 32'(bus.F), 32'(f));
    chk({name, " P"}, 32'(bus.P), 32'(p));
    chk({name, " id"}, 32'(bus.id), 32'(r));
    f_s = bus.F; p_s = bus.P; id_s = bus.id;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " hold valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, " hold F"}, 32'(bus.F), 32'(f_s));
      chk({name, " hold P"}, 32'(bus.P), 32'(p_s));
      chk({name, " hold id"}, 32'(bus.id), 32'(id_s));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({name, " valid drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  vec_t vecs[7];
  int   n;
  int   ack1_cnt;
  int   id_exp;

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.U0 = 8'h00;  bus.U1 = 8'h00;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;

    vecs[0] = '{r: 1'b0, u: 8'h01, lat: 9, f: 8'h80, p: 3'd0};
    vecs[1] = '{r: 1'b1, u: 8'hFF, lat: 2, f: 8'hFF, p: 3'd7};
    vecs[2] = '{r: 1'b0, u: 8'h00, lat: 2, f: 8'h00, p: 3'd0};
    vecs[3] = '{r: 1'b0, u: 8'h40, lat: 3, f: 8'h80, p: 3'd6};
    vecs[4] = '{r: 1'b1, u: 8'h02, lat: 8, f: 8'h80, p: 3'd1};
    vecs[5] = '{r: 1'b0, u: 8'h05, lat: 7, f: 8'hA0, p: 3'd2};
    vecs[6] = '{r: 1'b1, u: 8'h00, lat: 2, f: 8'h00, p: 3'd0};

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset F", 32'(bus.F), 32'd0);
    chk("reset P", 32'(bus.P), 32'd0);
    chk("reset id", 32'(bus.id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle ack0", 32'(bus.ack0), 32'd0);
    chk("idle ack1", 32'(bus.ack1), 32'd0);

    for (int i = 0; i < 7; i++)
      do_conv(vecs[i].r, vecs[i].u, vecs[i].lat, vecs[i].f, vecs[i].p, 0, $sformatf("vec%0d", i));

    do_conv(1'b1, 8'hC3, 2, 8'hC3, 3'd7, 5, "hold");

    // Continuous tie from a freshly reset pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.U0 = 8'h10; bus.U1 = 8'h05;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.out_ready = 1'b1;
    ack1_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      if (bus.ack1) ack1_cnt++;
      while (!bus.out_valid && n < 50) begin
        @(negedge clk); n++;
        if (bus.ack1) ack1_cnt++;
      end
`ifdef FLOAT_ARB_RR_EN
      id_exp = k % 2;
`else
      id_exp = 0;
`endif
      chk($sformatf("tie%0d id", k), 32'(bus.id), 32'(id_exp));
      chk($sformatf("tie%0d F", k), 32'(bus.F), (id_exp != 0) ? 32'h0A0 : 32'h080);
      chk($sformatf("tie%0d P", k), 32'(bus.P), (id_exp != 0) ? 32'd2 : 32'd4);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
`ifdef FLOAT_ARB_RR_EN
    chk("tie ack1 count", 32'(ack1_cnt), 32'd2);
`else
    chk("tie ack1 count", 32'(ack1_cnt), 32'd0);
`endif
    repeat (3) @(negedge clk);

    // Reset in the middle of a long normalization
    bus.U0 = 8'h03; bus.req0 = 1'b1;
    #1;
    n = 0;
    while (!bus.ack0 && n < 50) begin @(negedge clk); #1; n++; end
    chk("midreset ack", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset busy before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset F", 32'(bus.F), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("midreset no result", 32'(n), 32'd0);
    do_conv(1'b0, 8'h03, 8, 8'hC0, 3'd1, 0, "rerequest");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
